// File: rtl/sub_c_sched_if.sv
// Requester-side bus of the sub_c scheduler: request/operand in, grant/done/result out.
// master = requester side, slave = scheduler side.
interface sub_c_sched_if #(
    parameter int unsigned NREQ = 4
) ();
    logic [NREQ-1:0]   req_i;
    logic [3*NREQ-1:0] opnd_i;
    logic [NREQ-1:0]   gnt_o;
    logic [NREQ-1:0]   done_o;
    logic [1:0]        res_o;
    logic              busy_o;

    modport master (
        output req_i,
        output opnd_i,
        input  gnt_o,
        input  done_o,
        input  res_o,
        input  busy_o
    );

    modport slave (
        input  req_i,
        input  opnd_i,
        output gnt_o,
        output done_o,
        output res_o,
        output busy_o
    );
endinterface

// File: rtl/sub_c_sched.sv
// Round-robin scheduler sharing one sub_c datapath among NREQ requesters.
// Operands are held on the datapath for HOLD cycles, then the result is captured and returned.
module sub_c_sched #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned HOLD = 2
) (
    input  logic          clk,
    input  logic          rst,
    sub_c_sched_if.slave  bus,
    output logic          testi1_c,
    output logic          testi2_c,
    output logic          testi3_c,
    input  logic          testo1_c,
    input  logic          testo2_c
);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = (HOLD > 0) ? $clog2(HOLD + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        opnd_q, opnd_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [1:0]        res_q, res_d;
    logic              busy_q, busy_d;
    logic [2:0]        testi_q, testi_d;

    logic              found;
    int unsigned       win_k;
    int unsigned       scan_k;

    // Rotating-priority scan starting at ptr_q, wrapping modulo NREQ.
    always_comb begin
        found  = 1'b0;
        win_k  = 0;
        scan_k = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            scan_k = 32'(ptr_q) + i;
            if (scan_k >= NREQ) scan_k = scan_k - NREQ;
            if (!found && bus.req_i[scan_k]) begin
                found = 1'b1;
                win_k = scan_k;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        opnd_d  = opnd_q;
        gnt_d   = '0;
        done_d  = '0;
        res_d   = res_q;
        busy_d  = busy_q;
        testi_d = '0;
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (found) begin
                    idx_d          = IW'(win_k);
                    opnd_d         = bus.opnd_i[3*win_k +: 3];
                    gnt_d[IW'(win_k)] = 1'b1;
                    cnt_d          = '0;
                    busy_d         = 1'b1;
                    testi_d        = bus.opnd_i[3*win_k +: 3];
                    state_d        = S_RUN;
                end
            end
            S_RUN: begin
                testi_d = opnd_q;
                cnt_d   = cnt_q + 1'b1;
                // The last hold cycle samples the datapath and releases the operands.
                if (cnt_q == CW'(HOLD - 1)) begin
                    res_d         = {testo2_c, testo1_c};
                    done_d[idx_q] = 1'b1;
                    testi_d       = '0;
                    state_d       = S_DONE;
                end
            end
            S_DONE: begin
                ptr_d   = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            opnd_q  <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            testi_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            opnd_q  <= opnd_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            res_q   <= res_d;
            busy_q  <= busy_d;
            testi_q <= testi_d;
        end
    end

    assign bus.gnt_o  = gnt_q;
    assign bus.done_o = done_q;
    assign bus.res_o  = res_q;
    assign bus.busy_o = busy_q;
    assign testi1_c   = testi_q[0];
    assign testi2_c   = testi_q[1];
    assign testi3_c   = testi_q[2];
endmodule

// File: tb/tb_sub_c_sched.sv
// Bench for sub_c_sched: two instances (HOLD=2 and HOLD=1) checked every cycle against
// a transaction-timing reference model, plus directed scenarios.
module tb_sub_c_sched;
    localparam int NR = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NR-1:0]   req_a = '0, req_b = '0;
    logic [3*NR-1:0] op_a = '0, op_b = '0;
    logic ti_a1, ti_a2, ti_a3, to_a1, to_a2;
    logic ti_b1, ti_b2, ti_b3, to_b1, to_b2;

    sub_c_sched_if #(.NREQ(NR)) bus_a ();
    sub_c_sched_if #(.NREQ(NR)) bus_b ();
    assign bus_a.req_i  = req_a;
    assign bus_a.opnd_i = op_a;
    assign bus_b.req_i  = req_b;
    assign bus_b.opnd_i = op_b;

    // sub_c datapath behaviour
    assign to_a1 = ti_a1 ^ ti_a2;
    assign to_a2 = ti_a2 ^ ti_a3;
    assign to_b1 = ti_b1 ^ ti_b2;
    assign to_b2 = ti_b2 ^ ti_b3;

    sub_c_sched #(.NREQ(NR), .HOLD(2)) u_dut_a (
        .clk(clk), .rst(rst), .bus(bus_a),
        .testi1_c(ti_a1), .testi2_c(ti_a2), .testi3_c(ti_a3),
        .testo1_c(to_a1), .testo2_c(to_a2)
    );
    sub_c_sched #(.NREQ(NR), .HOLD(1)) u_dut_b (
        .clk(clk), .rst(rst), .bus(bus_b),
        .testi1_c(ti_b1), .testi2_c(ti_b2), .testi3_c(ti_b3),
        .testo1_c(to_b1), .testo2_c(to_b2)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;
    int hold [2] = '{2, 1};

    // Reference model: one operation at a time, described by its start edge.
    int       m_next  [2];
    int       m_start [2];
    bit       m_act   [2];
    int       m_w     [2];
    logic [2:0] m_op  [2];
    int       m_ptr   [2];
    logic [1:0] m_res [2];

    bit pend [2][NR];
    logic [2:0] pop [2][NR];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
        end
    endtask

    task automatic read_out(input int d, output logic [NR-1:0] g, output logic [NR-1:0] dn,
                            output logic [1:0] r, output logic b, output logic [2:0] ti);
        if (d == 0) begin
            g = bus_a.gnt_o; dn = bus_a.done_o; r = bus_a.res_o; b = bus_a.busy_o;
            ti = {ti_a3, ti_a2, ti_a1};
        end else begin
            g = bus_b.gnt_o; dn = bus_b.done_o; r = bus_b.res_o; b = bus_b.busy_o;
            ti = {ti_b3, ti_b2, ti_b1};
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_next[d] = 0; m_start[d] = 0; m_act[d] = 1'b0; m_w[d] = 0;
            m_op[d] = '0; m_ptr[d] = 0; m_res[d] = '0;
        end
    endtask

    task automatic arb(input int d, input logic [NR-1:0] req, input logic [3*NR-1:0] op);
        int e;
        bit got;
        e = edge_n + 1;
        got = 1'b0;
        if (e >= m_next[d] && req != '0) begin
            for (int i = 0; i < NR; i++) begin
                int k;
                k = (m_ptr[d] + i) % NR;
                if (!got && req[k]) begin
                    got = 1'b1;
                    m_w[d] = k;
                    m_op[d] = op[3*k +: 3];
                end
            end
            m_act[d]   = 1'b1;
            m_start[d] = e;
            m_next[d]  = e + hold[d] + 2;
            m_ptr[d]   = (m_w[d] + 1) % NR;
        end
    endtask

    task automatic cmp(input int d);
        logic [NR-1:0] g, dn, eg, ed;
        logic [1:0] r;
        logic b, eb;
        logic [2:0] ti, eti;
        int s, h;
        read_out(d, g, dn, r, b, ti);
        s = m_start[d]; h = hold[d];
        eg  = (m_act[d] && edge_n == s) ? NR'(1) << m_w[d] : '0;
        ed  = (m_act[d] && edge_n == s + h) ? NR'(1) << m_w[d] : '0;
        eti = (m_act[d] && edge_n >= s && edge_n <= s + h - 1) ? m_op[d] : 3'b000;
        eb  = m_act[d] && edge_n >= s && edge_n <= s + h;
        if (ed != '0)
            m_res[d] = {m_op[d][1] ^ m_op[d][2], m_op[d][0] ^ m_op[d][1]};
        check($sformatf("d%0d_gnt", d), 32'(g), 32'(eg));
        check($sformatf("d%0d_done", d), 32'(dn), 32'(ed));
        check($sformatf("d%0d_res", d), 32'(r), 32'(m_res[d]));
        check($sformatf("d%0d_busy", d), 32'(b), 32'(eb));
        check($sformatf("d%0d_testi", d), 32'(ti), 32'(eti));
    endtask

    task automatic step();
        arb(0, req_a, op_a);
        arb(1, req_b, op_b);
        @(posedge clk);
        edge_n++;
        #1;
        cmp(0);
        cmp(1);
    endtask

    task automatic do_reset();
        logic [NR-1:0] g, dn;
        logic [1:0] r;
        logic b;
        logic [2:0] ti;
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            read_out(d, g, dn, r, b, ti);
            check($sformatf("rst%0d_gnt", d), 32'(g), 0);
            check($sformatf("rst%0d_done", d), 32'(dn), 0);
            check($sformatf("rst%0d_res", d), 32'(r), 0);
            check($sformatf("rst%0d_busy", d), 32'(b), 0);
            check($sformatf("rst%0d_testi", d), 32'(ti), 0);
        end
        model_reset();
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int gq_idx[$];
        int gq_edge[$];
        int n_g1;
        model_reset();

        // 1: single request, HOLD=2
        do_reset();
        req_a = 4'b0001; op_a = 12'h003;
        step();
        check("t1_gnt", 32'(bus_a.gnt_o), 32'h1);
        req_a = '0; op_a = 12'hfff;
        step();
        check("t1_testi", 32'({ti_a3, ti_a2, ti_a1}), 32'h3);
        step();
        check("t1_done", 32'(bus_a.done_o), 32'h1);
        check("t1_res", 32'(bus_a.res_o), 32'h2);
        step(); step();

        // 2: all requesting, rotation from ptr=0
        do_reset();
        req_a = 4'b1111; op_a = 12'ha5c;
        for (int c = 0; c < 18; c++) begin
            step();
            if (bus_a.gnt_o != '0) begin
                check("t2_onehot", 32'($countones(bus_a.gnt_o)), 1);
                for (int k = 0; k < NR; k++)
                    if (bus_a.gnt_o[k]) begin gq_idx.push_back(k); gq_edge.push_back(edge_n); end
            end
        end
        check("t2_count", 32'(gq_idx.size()), 5);
        for (int i = 0; i < gq_idx.size() && i < 5; i++) begin
            check("t2_order", 32'(gq_idx[i]), 32'(i % NR));
            if (i > 0) check("t2_spacing", 32'(gq_edge[i] - gq_edge[i-1]), 4);
        end

        // 3: after requester 2 completes, 3 outranks 0
        do_reset();
        req_a = 4'b0100;
        step();
        req_a = '0;
        repeat (3) step();
        gq_idx.delete();
        req_a = 4'b1001;
        for (int c = 0; c < 10; c++) begin
            step();
            for (int k = 0; k < NR; k++)
                if (bus_a.gnt_o[k]) gq_idx.push_back(k);
            req_a &= ~bus_a.gnt_o;
        end
        check("t3_count", 32'(gq_idx.size()), 2);
        if (gq_idx.size() >= 2) begin
            check("t3_first", 32'(gq_idx[0]), 3);
            check("t3_second", 32'(gq_idx[1]), 0);
        end

        // 4: request pulse while busy is dropped
        do_reset();
        req_a = 4'b0001;
        step();
        req_a = 4'b0010;
        step();
        req_a = '0;
        n_g1 = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (bus_a.gnt_o[1]) n_g1++;
        end
        check("t4_no_gnt1", 32'(n_g1), 0);
        check("t4_busy", 32'(bus_a.busy_o), 0);

        // 5: reset in second RUN cycle, then a fresh request
        do_reset();
        req_a = 4'b0001;
        step();
        req_a = '0;
        step();
        do_reset();
        repeat (3) step();
        req_a = 4'b0100; op_a = 12'h700;
        step();
        check("t5_gnt", 32'(bus_a.gnt_o), 32'h4);
        req_a = '0;
        repeat (4) step();

        // 6: HOLD=1 instance
        do_reset();
        req_b = 4'b0001; op_b = 12'h005;
        step();
        check("t6_gnt", 32'(bus_b.gnt_o), 32'h1);
        check("t6_testi", 32'({ti_b3, ti_b2, ti_b1}), 32'h5);
        req_b = '0;
        step();
        check("t6_done", 32'(bus_b.done_o), 32'h1);
        check("t6_res", 32'(bus_b.res_o), 32'h3);
        step(); step();

        // randomized traffic on both instances, with occasional resets
        for (int c = 0; c < 3000; c++) begin
            for (int d = 0; d < 2; d++)
                for (int k = 0; k < NR; k++) begin
                    if (!pend[d][k] && $urandom_range(0, 4) == 0) begin
                        pend[d][k] = 1'b1;
                        pop[d][k] = 3'($urandom_range(0, 7));
                    end else if (pend[d][k] && $urandom_range(0, 24) == 0) begin
                        pend[d][k] = 1'b0;
                    end
                end
            for (int k = 0; k < NR; k++) begin
                req_a[k] = pend[0][k];
                req_b[k] = pend[1][k];
                op_a[3*k +: 3] = pend[0][k] ? pop[0][k] : 3'($urandom_range(0, 7));
                op_b[3*k +: 3] = pend[1][k] ? pop[1][k] : 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 299) == 0) do_reset();
            else step();
            for (int k = 0; k < NR; k++) begin
                if (bus_a.gnt_o[k]) pend[0][k] = 1'b0;
                if (bus_b.gnt_o[k]) pend[1][k] = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
